// File: rtl/display_timings_pkg.sv
// display_timings_pkg: shared types and helpers for the programmable timing generator.
//   timing_cfg_t    - one requested mode (porches, sync, resolution, polarity)
//   timing_bounds_t - signed counter compare points derived from a mode
//   derive_bounds() - mode -> compare points
//   cfg_legal()     - accept/reject check applied when a request is captured
package display_timings_pkg;

    localparam int CFG_W  = 12;
    localparam int CORD_W = 16;

    typedef logic signed [CORD_W-1:0] coord_t;

    typedef struct packed {
        logic [CFG_W-1:0] h_res, h_fp, h_sync, h_bp;
        logic [CFG_W-1:0] v_res, v_fp, v_sync, v_bp;
        logic             h_pol, v_pol;
    } timing_cfg_t;

    typedef struct packed {
        coord_t h_sta, hs_sta, hs_end, ha_end;
        coord_t v_sta, vs_sta, vs_end, va_end;
        logic   h_pol, v_pol;
    } timing_bounds_t;

    localparam timing_cfg_t DEF_480P = '{
        h_res: 12'd640,  h_fp: 12'd16,  h_sync: 12'd96, h_bp: 12'd48,
        v_res: 12'd480,  v_fp: 12'd10,  v_sync: 12'd2,  v_bp: 12'd33,
        h_pol: 1'b0,     v_pol: 1'b0};

    localparam timing_cfg_t DEF_720P = '{
        h_res: 12'd1280, h_fp: 12'd110, h_sync: 12'd40, h_bp: 12'd220,
        v_res: 12'd720,  v_fp: 12'd5,   v_sync: 12'd5,  v_bp: 12'd20,
        h_pol: 1'b1,     v_pol: 1'b1};

    // Blanking lives at negative coordinates so the active area starts at (0,0).
    function automatic timing_bounds_t derive_bounds(input timing_cfg_t c);
        timing_bounds_t b;
        b.h_sta  = -(coord_t'(c.h_fp) + coord_t'(c.h_sync) + coord_t'(c.h_bp));
        b.hs_sta = b.h_sta + coord_t'(c.h_fp);
        b.hs_end = b.hs_sta + coord_t'(c.h_sync);
        b.ha_end = coord_t'(c.h_res) - coord_t'(1);
        b.v_sta  = -(coord_t'(c.v_fp) + coord_t'(c.v_sync) + coord_t'(c.v_bp));
        b.vs_sta = b.v_sta + coord_t'(c.v_fp);
        b.vs_end = b.vs_sta + coord_t'(c.v_sync);
        b.va_end = coord_t'(c.v_res) - coord_t'(1);
        b.h_pol  = c.h_pol;
        b.v_pol  = c.v_pol;
        return b;
    endfunction

    // Zero-size active/sync fields and totals that overflow the signed
    // coordinate range cannot be represented by the counters.
    function automatic logic cfg_legal(input timing_cfg_t c);
        int h_tot, v_tot, lim;
        h_tot = int'(c.h_res) + int'(c.h_fp) + int'(c.h_sync) + int'(c.h_bp);
        v_tot = int'(c.v_res) + int'(c.v_fp) + int'(c.v_sync) + int'(c.v_bp);
        lim   = (2 ** (CORD_W - 1)) - 1;
        return (c.h_res != '0) && (c.v_res != '0) &&
               (c.h_sync != '0) && (c.v_sync != '0) &&
               (h_tot <= lim) && (v_tot <= lim);
    endfunction

endpackage

// File: rtl/display_cfg_shadow.sv
// display_cfg_shadow: single-entry pending-mode register behind a valid/ready handshake.
//   req/cfg_valid/cfg_ready - request capture; the slot stays busy until the
//                             new mode's first frame is on the outputs
//   cfg_err                 - one-cycle pulse when a captured request is illegal
//   frame_end               - counter is on the last pixel of the frame
//   apply_ok                - pending mode is being loaded this cycle
//   pend_bnd                - pending mode, already converted to compare points
//   mode_applied            - one-cycle pulse aligned with the new mode's frame pulse
module display_cfg_shadow
    import display_timings_pkg::*;
(
    input  logic           clk_pix,
    input  logic           rst,
    input  timing_cfg_t    req,
    input  logic           cfg_valid,
    input  logic           frame_end,
    output logic           cfg_ready,
    output logic           cfg_err,
    output logic           apply_ok,
    output timing_bounds_t pend_bnd,
    output logic           mode_applied
);

    logic full;
    logic applied_q;

    // Ready is held low one extra cycle after the load so it returns in step
    // with mode_applied and the new mode's frame pulse.
    assign cfg_ready = !full && !applied_q;
    // A capture happens only while empty, so a capture on the frame-end cycle
    // cannot apply until the next frame end.
    assign apply_ok  = full && frame_end;

    always_ff @(posedge clk_pix) begin
        if (rst) begin
            full         <= 1'b0;
            applied_q    <= 1'b0;
            mode_applied <= 1'b0;
            cfg_err      <= 1'b0;
            pend_bnd     <= '0;
        end else begin
            cfg_err      <= 1'b0;
            applied_q    <= apply_ok;
            mode_applied <= applied_q;
            if (apply_ok) begin
                full <= 1'b0;
            end else if (cfg_valid && cfg_ready) begin
                if (cfg_legal(req)) begin
                    full     <= 1'b1;
                    pend_bnd <= derive_bounds(req);
                end else begin
                    cfg_err  <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/display_timings_prog.sv
// display_timings_prog: runtime-programmable raster timing generator.
//   clk_pix, rst        - pixel clock, synchronous active-high reset
//   cfg_* / cfg_valid   - requested mode; cfg_ready, cfg_err handshake status
//   mode_applied        - pulse with the first frame pulse of a newly loaded mode
//   hsync, vsync        - syncs at the polarity of the current mode
//   de, frame, line     - data enable, start of frame, start of active line
//   sx, sy              - signed screen position, aligned with the syncs
// Optional (DISPLAY_TIMINGS_VBLANK_IRQ_EN): irq_clr in, irq_vblank out, a
// sticky flag raised when the last active pixel of a frame has been sent.
module display_timings_prog
    import display_timings_pkg::*;
#(
    parameter int   CORDW      = CORD_W,
    parameter int   CFGW       = CFG_W,
    parameter int   DEF_H_RES  = 640,
    parameter int   DEF_H_FP   = 16,
    parameter int   DEF_H_SYNC = 96,
    parameter int   DEF_H_BP   = 48,
    parameter int   DEF_V_RES  = 480,
    parameter int   DEF_V_FP   = 10,
    parameter int   DEF_V_SYNC = 2,
    parameter int   DEF_V_BP   = 33,
    parameter logic DEF_H_POL  = 1'b0,
    parameter logic DEF_V_POL  = 1'b0
) (
    input  logic                    clk_pix,
    input  logic                    rst,
    input  logic [CFGW-1:0]         cfg_h_res,
    input  logic [CFGW-1:0]         cfg_h_fp,
    input  logic [CFGW-1:0]         cfg_h_sync,
    input  logic [CFGW-1:0]         cfg_h_bp,
    input  logic [CFGW-1:0]         cfg_v_res,
    input  logic [CFGW-1:0]         cfg_v_fp,
    input  logic [CFGW-1:0]         cfg_v_sync,
    input  logic [CFGW-1:0]         cfg_v_bp,
    input  logic                    cfg_h_pol,
    input  logic                    cfg_v_pol,
    input  logic                    cfg_valid,
    output logic                    cfg_ready,
    output logic                    cfg_err,
    output logic                    mode_applied,
    output logic                    hsync,
    output logic                    vsync,
    output logic                    de,
    output logic                    frame,
    output logic                    line,
    output logic signed [CORDW-1:0] sx,
    output logic signed [CORDW-1:0] sy
`ifdef DISPLAY_TIMINGS_VBLANK_IRQ_EN
    ,
    input  logic                    irq_clr,
    output logic                    irq_vblank
`endif
);

    localparam timing_cfg_t DEF_CFG = '{
        h_res: CFG_W'(DEF_H_RES), h_fp: CFG_W'(DEF_H_FP),
        h_sync: CFG_W'(DEF_H_SYNC), h_bp: CFG_W'(DEF_H_BP),
        v_res: CFG_W'(DEF_V_RES), v_fp: CFG_W'(DEF_V_FP),
        v_sync: CFG_W'(DEF_V_SYNC), v_bp: CFG_W'(DEF_V_BP),
        h_pol: DEF_H_POL, v_pol: DEF_V_POL};
    localparam coord_t DEF_H_STA = coord_t'(-(DEF_H_FP + DEF_H_SYNC + DEF_H_BP));
    localparam coord_t DEF_V_STA = coord_t'(-(DEF_V_FP + DEF_V_SYNC + DEF_V_BP));

    timing_cfg_t    req;
    timing_bounds_t bnd;       // active mode
    timing_bounds_t pend_bnd;  // pending mode from the shadow
    coord_t         x, y;
    logic           frame_end, apply_ok, hs_act, vs_act;

    assign req = '{cfg_h_res, cfg_h_fp, cfg_h_sync, cfg_h_bp,
                   cfg_v_res, cfg_v_fp, cfg_v_sync, cfg_v_bp,
                   cfg_h_pol, cfg_v_pol};

    assign frame_end = (x == bnd.ha_end) && (y == bnd.va_end);
    assign hs_act    = ($signed(bnd.hs_sta) < x) && (x <= $signed(bnd.hs_end));
    assign vs_act    = ($signed(bnd.vs_sta) < y) && (y <= $signed(bnd.vs_end));

    display_cfg_shadow u_shadow (
        .clk_pix      (clk_pix),
        .rst          (rst),
        .req          (req),
        .cfg_valid    (cfg_valid),
        .frame_end    (frame_end),
        .cfg_ready    (cfg_ready),
        .cfg_err      (cfg_err),
        .apply_ok     (apply_ok),
        .pend_bnd     (pend_bnd),
        .mode_applied (mode_applied)
    );

    // Mode swaps only on the last pixel of a frame, so the counters jump
    // straight to the new mode's blanking origin.
    always_ff @(posedge clk_pix) begin
        if (rst) begin
            bnd <= derive_bounds(DEF_CFG);
            x   <= DEF_H_STA;
            y   <= DEF_V_STA;
        end else if (apply_ok) begin
            bnd <= pend_bnd;
            x   <= pend_bnd.h_sta;
            y   <= pend_bnd.v_sta;
        end else if (x == bnd.ha_end) begin
            x   <= bnd.h_sta;
            y   <= (y == bnd.va_end) ? bnd.v_sta : y + coord_t'(1);
        end else begin
            x   <= x + coord_t'(1);
        end
    end

    // Everything here is built from the same x/y/bnd, so a mode change shows
    // up on all outputs together at the first cycle of the new frame.
    always_ff @(posedge clk_pix) begin
        if (rst) begin
            hsync <= ~DEF_H_POL;
            vsync <= ~DEF_V_POL;
            de    <= 1'b0;
            frame <= 1'b0;
            line  <= 1'b0;
            sx    <= DEF_H_STA;
            sy    <= DEF_V_STA;
        end else begin
            hsync <= bnd.h_pol ? hs_act : ~hs_act;
            vsync <= bnd.v_pol ? vs_act : ~vs_act;
            de    <= !x[CORD_W-1] && !y[CORD_W-1];
            frame <= (x == bnd.h_sta) && (y == bnd.v_sta);
            line  <= !y[CORD_W-1] && (x == bnd.h_sta);
            sx    <= x;
            sy    <= y;
        end
    end

`ifdef DISPLAY_TIMINGS_VBLANK_IRQ_EN
    // last_px_q lines up with the last pixel on sx/sy; the flag follows one
    // cycle later, together with de falling. Set beats clear.
    logic last_px_q;

    always_ff @(posedge clk_pix) begin
        if (rst) begin
            last_px_q  <= 1'b0;
            irq_vblank <= 1'b0;
        end else begin
            last_px_q <= frame_end;
            if (last_px_q) begin
                irq_vblank <= 1'b1;
            end else if (irq_clr) begin
                irq_vblank <= 1'b0;
            end
        end
    end
`endif

endmodule

// File: tb/tb_display_timings_prog.sv
// Directed bench for display_timings_prog. Reset defaults are overridden to a
// small mode (h 16/2/4/2, v 6/1/2/1, pol 0/0: 24x10 = 240 cycles per frame)
// so full frames fit in a short run. Outputs are sampled on the falling edge
// and inputs driven right after the sample.
module tb_display_timings_prog;

    localparam int CORDW = 16;
    localparam int CFGW  = 12;

    logic clk_pix = 1'b0;
    logic rst = 1'b1;
    logic [CFGW-1:0] cfg_h_res = '0, cfg_h_fp = '0, cfg_h_sync = '0, cfg_h_bp = '0;
    logic [CFGW-1:0] cfg_v_res = '0, cfg_v_fp = '0, cfg_v_sync = '0, cfg_v_bp = '0;
    logic cfg_h_pol = 1'b0, cfg_v_pol = 1'b0, cfg_valid = 1'b0;
    logic cfg_ready, cfg_err, mode_applied, hsync, vsync, de, frame, line;
    logic signed [CORDW-1:0] sx, sy;
`ifdef DISPLAY_TIMINGS_VBLANK_IRQ_EN
    logic irq_clr = 1'b0;
    logic irq_vblank;
`endif

    always #5 clk_pix = ~clk_pix;

    display_timings_prog #(
        .CORDW(CORDW), .CFGW(CFGW),
        .DEF_H_RES(16), .DEF_H_FP(2), .DEF_H_SYNC(4), .DEF_H_BP(2),
        .DEF_V_RES(6),  .DEF_V_FP(1), .DEF_V_SYNC(2), .DEF_V_BP(1),
        .DEF_H_POL(1'b0), .DEF_V_POL(1'b0)
    ) dut (
        .clk_pix(clk_pix), .rst(rst),
        .cfg_h_res(cfg_h_res), .cfg_h_fp(cfg_h_fp), .cfg_h_sync(cfg_h_sync), .cfg_h_bp(cfg_h_bp),
        .cfg_v_res(cfg_v_res), .cfg_v_fp(cfg_v_fp), .cfg_v_sync(cfg_v_sync), .cfg_v_bp(cfg_v_bp),
        .cfg_h_pol(cfg_h_pol), .cfg_v_pol(cfg_v_pol), .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready), .cfg_err(cfg_err), .mode_applied(mode_applied),
        .hsync(hsync), .vsync(vsync), .de(de), .frame(frame), .line(line),
        .sx(sx), .sy(sy)
`ifdef DISPLAY_TIMINGS_VBLANK_IRQ_EN
        , .irq_clr(irq_clr), .irq_vblank(irq_vblank)
`endif
    );

    int errors = 0;
    int checks = 0;
    int st_len, st_de, st_hs1, st_vs1, st_line, st_ma;
    int st_sxmin, st_sxmax, st_symin, st_symax, st_hsmin, st_hsmax;

    task automatic tick();
        @(negedge clk_pix);
    endtask

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic set_cfg(input int hr, input int hf, input int hs, input int hb,
                           input int vr, input int vf, input int vs, input int vb,
                           input logic hp, input logic vp);
        cfg_h_res = CFGW'(hr); cfg_h_fp = CFGW'(hf); cfg_h_sync = CFGW'(hs); cfg_h_bp = CFGW'(hb);
        cfg_v_res = CFGW'(vr); cfg_v_fp = CFGW'(vf); cfg_v_sync = CFGW'(vs); cfg_v_bp = CFGW'(vb);
        cfg_h_pol = hp; cfg_v_pol = vp;
    endtask

    // Starts on a sample where frame==1, accumulates one whole frame and
    // returns on the next frame==1 sample (bounded).
    task automatic frame_stats();
        int vx, vy;
        st_len = 0; st_de = 0; st_hs1 = 0; st_vs1 = 0; st_line = 0; st_ma = 0;
        st_sxmin = 9999; st_sxmax = -9999; st_symin = 9999; st_symax = -9999;
        st_hsmin = 9999; st_hsmax = -9999;
        do begin
            vx = sx; vy = sy;
            st_len++;
            if (de)   st_de++;
            if (vsync) st_vs1++;
            if (line) st_line++;
            if (st_len > 1 && mode_applied) st_ma++;
            if (hsync) begin
                st_hs1++;
                if (vx < st_hsmin) st_hsmin = vx;
                if (vx > st_hsmax) st_hsmax = vx;
            end
            if (vx < st_sxmin) st_sxmin = vx;
            if (vx > st_sxmax) st_sxmax = vx;
            if (vy < st_symin) st_symin = vy;
            if (vy > st_symax) st_symax = vy;
            tick();
        end while (!frame && st_len < 2000);
    endtask

    initial begin
        int n, rdy_hi, fr_hi;

        // ---- reset state
        repeat (3) tick();
        chk("rst_hsync", hsync, 1);
        chk("rst_vsync", vsync, 1);
        chk("rst_de", de, 0);
        chk("rst_frame", frame, 0);
        chk("rst_line", line, 0);
        chk("rst_sx", sx, -8);
        chk("rst_sy", sy, -4);
        chk("rst_ready", cfg_ready, 1);
        chk("rst_err", cfg_err, 0);
        chk("rst_applied", mode_applied, 0);

        // ---- default mode, one full frame
        rst = 1'b0;
        tick();
        chk("def_first_frame", frame, 1);
        frame_stats();
        chk("def_len", st_len, 240);
        chk("def_de", st_de, 96);
        chk("def_hsync_hi", st_hs1, 200);
        chk("def_vsync_hi", st_vs1, 192);
        chk("def_lines", st_line, 6);
        chk("def_sxmin", st_sxmin, -8);
        chk("def_sxmax", st_sxmax, 15);
        chk("def_symin", st_symin, -4);
        chk("def_symax", st_symax, 5);

        // ---- load small mode, then a second request under back-pressure
        set_cfg(8, 1, 2, 1, 4, 1, 1, 1, 1'b1, 1'b1);
        cfg_valid = 1'b1;
        tick();
        cfg_valid = 1'b0;
        chk("cap_ready_low", cfg_ready, 0);
        chk("cap_err", cfg_err, 0);
        set_cfg(4, 1, 1, 1, 4, 1, 1, 1, 1'b0, 1'b0);
        cfg_valid = 1'b1;
        tick();
        tick();
        cfg_valid = 1'b0;
        n = 0; rdy_hi = 0;
        while (!mode_applied && n < 1000) begin
            if (cfg_ready) rdy_hi++;
            tick();
            n++;
        end
        chk("applied_seen", mode_applied, 1);
        chk("bp_ready_low", rdy_hi, 0);
        chk("apply_frame", frame, 1);
        chk("apply_ready", cfg_ready, 1);
        chk("apply_sx", sx, -4);
        chk("apply_sy", sy, -3);
        chk("apply_hsync", hsync, 0);
        chk("apply_vsync", vsync, 0);
        frame_stats();
        chk("small_len", st_len, 84);
        chk("small_de", st_de, 32);
        chk("small_hsync_hi", st_hs1, 14);
        chk("small_hs_sxmin", st_hsmin, -2);
        chk("small_hs_sxmax", st_hsmax, -1);
        chk("small_vsync_hi", st_vs1, 12);
        chk("small_lines", st_line, 4);
        chk("small_sxmin", st_sxmin, -4);
        chk("small_sxmax", st_sxmax, 7);
        chk("small_symin", st_symin, -3);
        chk("small_symax", st_symax, 3);
        chk("small_no_reapply", st_ma, 0);
        chk("small_ready", cfg_ready, 1);

        // ---- illegal request (h_sync = 0)
        set_cfg(8, 1, 0, 1, 4, 1, 1, 1, 1'b1, 1'b1);
        cfg_valid = 1'b1;
        tick();
        cfg_valid = 1'b0;
        chk("rej_err", cfg_err, 1);
        chk("rej_ready", cfg_ready, 1);
        tick();
        chk("rej_err_pulse", cfg_err, 0);
        n = 0;
        while (!frame && n < 200) begin tick(); n++; end
        frame_stats();
        chk("rej_len", st_len, 84);
        chk("rej_hsync_hi", st_hs1, 14);
        chk("rej_no_apply", st_ma, 0);

        // ---- pending request discarded by a mid-frame reset
        set_cfg(8, 1, 2, 1, 4, 1, 1, 1, 1'b0, 1'b0);
        cfg_valid = 1'b1;
        tick();
        cfg_valid = 1'b0;
        chk("pend_ready_low", cfg_ready, 0);
        repeat (20) tick();
        rst = 1'b1;
        fr_hi = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (frame) fr_hi++;
        end
        chk("mrst_frame_low", fr_hi, 0);
        chk("mrst_sx", sx, -8);
        chk("mrst_sy", sy, -4);
        chk("mrst_ready", cfg_ready, 1);
        chk("mrst_hsync", hsync, 1);
        rst = 1'b0;
        tick();
        chk("mrst_frame", frame, 1);
        chk("mrst_applied", mode_applied, 0);
        frame_stats();
        chk("mrst_len", st_len, 240);
        chk("mrst_no_apply", st_ma, 0);

        // ---- capture on the frame-end cycle waits for the following frame end
        n = 0;
        while (!(sx == 14 && sy == 5) && n < 500) begin tick(); n++; end
        set_cfg(8, 1, 2, 1, 4, 1, 1, 1, 1'b1, 1'b1);
        cfg_valid = 1'b1;
        tick();
        cfg_valid = 1'b0;
        chk("edge_ready_low", cfg_ready, 0);
        tick();
        chk("edge_frame", frame, 1);
        chk("edge_not_applied", mode_applied, 0);
        frame_stats();
        chk("edge_old_len", st_len, 240);
        chk("edge_applied", mode_applied, 1);
        frame_stats();
        chk("edge_new_len", st_len, 84);

`ifdef DISPLAY_TIMINGS_VBLANK_IRQ_EN
        // ---- vblank flag: clear, then set coinciding with clear
        irq_clr = 1'b1;
        tick();
        irq_clr = 1'b0;
        n = 0;
        while (!(sx == 7 && sy == 3) && n < 200) begin tick(); n++; end
        chk("irq_before", irq_vblank, 0);
        chk("irq_last_de", de, 1);
        irq_clr = 1'b1;
        tick();
        chk("irq_set_wins", irq_vblank, 1);
        chk("irq_de_fall", de, 0);
        tick();
        irq_clr = 1'b0;
        chk("irq_cleared", irq_vblank, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
